// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer carrying an opaque payload and a control bundle.
// Latency: 1 cycle from an accepted input beat to out_valid when the stage is empty.
// Backpressure: in_ready is registered (= no skid entry next cycle), so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst (synchronous, active-low), flush (synchronous, drops every held beat)
//   in_valid / in_ready / in_data / in_ctrl     : upstream handshake and beat
//   out_valid / out_ready / out_data / out_ctrl : downstream handshake and beat (out_ctrl is 0 on bubbles)
//   occupancy                                   : beats currently held (0..2)
// Optional build macro PIPE_STAGE_STATS_EN adds stall_cnt[15:0] and drop_cnt[7:0], both saturating.

module pipe_stage_skid #(
    parameter int DATA_W = 48,
    parameter int CTRL_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [7:0]        drop_cnt
`endif
);

    logic              main_v_q,    main_v_d;
    logic              skid_v_q,    skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q,  in_ready_d;
    logic [1:0]        occ_q,       occ_d;

    logic accept;
    logic rel;

    always_comb begin
        accept      = in_valid && in_ready_q;
        rel         = main_v_q && out_ready;

        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // A beat released this same cycle was consumed downstream; everything else is dropped.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            // EMPTY
            if (accept) begin
                main_v_d    = 1'b1;
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end
        end else if (!skid_v_q) begin
            // ONE
            if (rel && accept) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end else if (rel) begin
                main_v_d = 1'b0;
            end else if (accept) begin
                skid_v_d    = 1'b1;
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
            end
        end else if (rel) begin
            // FULL: in_ready is low here, so only a release can move state.
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_v_d    = 1'b0;
        end

        in_ready_d = !skid_v_d;
        occ_d      = {1'b0, main_v_d} + {1'b0, skid_v_d};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    // Bubbles present a NOP control word regardless of what main_ctrl_q still holds.
    assign out_ctrl  = main_ctrl_q & {CTRL_W{main_v_q}};
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  drop_cnt_q,  drop_cnt_d;
    logic [2:0]  n_drop;
    logic [8:0]  drop_sum;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        // Held beats plus an input accepted in the flush cycle, minus one released downstream.
        n_drop   = {2'b00, main_v_q} + {2'b00, skid_v_q} + {2'b00, accept} - {2'b00, rel};
        drop_sum = {1'b0, drop_cnt_q} + {6'b0, n_drop};
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
